// File: rtl/servo_duty_ramp.sv
// servo_duty_ramp: synchronises and debounces a position switch, selects a
// duty endpoint, and slews the registered duty word toward it by at most STEP
// once per servo frame.
module servo_duty_ramp #(
    parameter int FRAME_CYCLES    = 500_000,
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int DUTY_LO         = 21,
    parameter int DUTY_HI         = 102,
    parameter int STEP            = 4
) (
    input  logic       CLK25MHZ,
    input  logic       reset,
    input  logic       sw_pos,
    output logic [9:0] duty_cycle,
    output logic       busy,
    output logic       at_target
);

    // Counter widths never collapse to zero bits for the degenerate parameter values.
    localparam int FRAME_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
    localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(1);
    localparam logic [9:0]         DUTY_LO_W  = 10'(DUTY_LO);
    localparam logic [9:0]         DUTY_HI_W  = 10'(DUTY_HI);
    localparam logic [10:0]        STEP_W     = 11'(STEP);

    typedef enum logic [0:0] {
        ST_HOLD = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    logic               sync1_r;
    logic               sync2_r;
    logic               sw_stable_r;
    logic [DEB_W-1:0]   deb_cnt_r;
    logic [FRAME_W-1:0] frame_cnt_r;
    logic               frame_tick_s;
    logic [9:0]         target_s;
    logic [10:0]        target_ext_s;
    logic [10:0]        duty_ext_s;
    logic [10:0]        diff_s;

    state_t             state_r;
    state_t             state_next_s;
    logic [9:0]         duty_r;
    logic [9:0]         duty_next_s;
    logic               busy_r;
    logic               busy_next_s;
    logic               at_target_r;
    logic               at_target_next_s;

    // Two-flop synchroniser for the asynchronous switch input.
    always_ff @(posedge CLK25MHZ or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= sw_pos;
            sync2_r <= sync1_r;
        end
    end

    // Debouncer: accept a new level only after it persists DEBOUNCE_CYCLES cycles.
    always_ff @(posedge CLK25MHZ or posedge reset) begin
        if (reset) begin
            sw_stable_r <= 1'b0;
            deb_cnt_r   <= '0;
        end else if (sync2_r == sw_stable_r) begin
            deb_cnt_r   <= '0;
        end else if (deb_cnt_r == DEB_LAST) begin
            sw_stable_r <= sync2_r;
            deb_cnt_r   <= '0;
        end else begin
            deb_cnt_r   <= deb_cnt_r + DEB_ONE;
        end
    end

    // Free-running frame timer; never restarted by switch activity.
    always_ff @(posedge CLK25MHZ or posedge reset) begin
        if (reset) begin
            frame_cnt_r <= '0;
        end else if (frame_cnt_r == FRAME_LAST) begin
            frame_cnt_r <= '0;
        end else begin
            frame_cnt_r <= frame_cnt_r + FRAME_ONE;
        end
    end

    assign frame_tick_s = (frame_cnt_r == FRAME_LAST);
    assign target_s     = sw_stable_r ? DUTY_HI_W : DUTY_LO_W;
    assign target_ext_s = {1'b0, target_s};
    assign duty_ext_s   = {1'b0, duty_r};

    // Unsigned distance to the target, one bit wider so it cannot wrap.
    always_comb begin
        diff_s = 11'd0;
        if (target_ext_s >= duty_ext_s) begin
            diff_s = target_ext_s - duty_ext_s;
        end else begin
            diff_s = duty_ext_s - target_ext_s;
        end
    end

    // Next-state and next-output logic for the HOLD/RAMP slew controller.
    always_comb begin
        state_next_s     = state_r;
        duty_next_s      = duty_r;
        at_target_next_s = 1'b0;
        case (state_r)
            ST_HOLD: begin
                // Entering RAMP never moves the duty word on the same edge.
                if (target_s != duty_r) begin
                    state_next_s = ST_RAMP;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_RAMP: begin
                if (frame_tick_s) begin
                    if (diff_s <= STEP_W) begin
                        duty_next_s      = target_s;
                        at_target_next_s = 1'b1;
                        state_next_s     = ST_HOLD;
                    end else if (target_ext_s > duty_ext_s) begin
                        duty_next_s = 10'(duty_ext_s + STEP_W);
                    end else begin
                        duty_next_s = 10'(duty_ext_s - STEP_W);
                    end
                end else begin
                    state_next_s = ST_RAMP;
                end
            end
            default: begin
                state_next_s = ST_HOLD;
            end
        endcase
        busy_next_s = (state_next_s == ST_RAMP);
    end

    // State and output registers; all outputs come straight from flops.
    always_ff @(posedge CLK25MHZ or posedge reset) begin
        if (reset) begin
            state_r     <= ST_HOLD;
            duty_r      <= DUTY_LO_W;
            busy_r      <= 1'b0;
            at_target_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            duty_r      <= duty_next_s;
            busy_r      <= busy_next_s;
            at_target_r <= at_target_next_s;
        end
    end

    assign duty_cycle = duty_r;
    assign busy       = busy_r;
    assign at_target  = at_target_r;

endmodule

// File: tb/tb_servo_duty_ramp.sv
// Scoreboard bench for servo_duty_ramp: stimulus pushes expected output
// changes into a queue, a negedge monitor pops and compares on every change.
module tb_servo_duty_ramp;

    localparam int FRAME = 16;
    localparam int DEB   = 8;

    typedef struct packed {
        logic [9:0] duty;
        logic       busy;
        logic       at;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       sw_pos;
    logic [9:0] duty_cycle;
    logic       busy;
    logic       at_target;
    logic [9:0] eq_duty;
    logic       eq_busy;
    logic       eq_at;

    int  compared   = 0;
    int  mismatched = 0;
    ev_t exp_q[$];
    int  eq_busy_seen = 0;
    int  eq_at_seen   = 0;
    int  eq_duty_bad  = 0;

    servo_duty_ramp #(
        .FRAME_CYCLES(FRAME), .DEBOUNCE_CYCLES(DEB),
        .DUTY_LO(21), .DUTY_HI(102), .STEP(4)
    ) dut (
        .CLK25MHZ(clk), .reset(reset), .sw_pos(sw_pos),
        .duty_cycle(duty_cycle), .busy(busy), .at_target(at_target)
    );

    servo_duty_ramp #(
        .FRAME_CYCLES(FRAME), .DEBOUNCE_CYCLES(DEB),
        .DUTY_LO(50), .DUTY_HI(50), .STEP(4)
    ) dut_eq (
        .CLK25MHZ(clk), .reset(reset), .sw_pos(sw_pos),
        .duty_cycle(eq_duty), .busy(eq_busy), .at_target(eq_at)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int req);
        compared = compared + 1;
        if (got != req) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic push(input int d, input logic b, input logic a);
        ev_t e;
        e.duty = 10'(d);
        e.busy = b;
        e.at   = a;
        exp_q.push_back(e);
    endtask

    task automatic wait_empty(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk);
        end
        compared   = compared + 1;
        mismatched = mismatched + 1;
        $display("FAIL %s_timeout: got %0d pending events, required 0", name, exp_q.size());
        exp_q.delete();
    endtask

    // Monitor: compare every change of {duty_cycle, busy, at_target} against the queue.
    initial begin
        ev_t cur;
        ev_t prev;
        ev_t exp;
        bit  armed     = 1'b0;
        bit  step_flag = 1'b0;
        int  cycle     = 0;
        int  last_step = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            cycle = cycle + 1;
            if (eq_busy !== 1'b0) eq_busy_seen = eq_busy_seen + 1;
            if (eq_at !== 1'b0) eq_at_seen = eq_at_seen + 1;
            if (eq_duty !== 10'd50) eq_duty_bad = eq_duty_bad + 1;
            cur = {duty_cycle, busy, at_target};
            if (!armed) begin
                prev  = cur;
                armed = 1'b1;
            end else if (cur !== prev) begin
                compared = compared + 1;
                if (exp_q.size() == 0) begin
                    mismatched = mismatched + 1;
                    $display("FAIL unexpected_event: got duty=%0d busy=%0b at_target=%0b, required no change",
                             cur.duty, cur.busy, cur.at);
                end else begin
                    exp = exp_q.pop_front();
                    if (cur !== exp) begin
                        mismatched = mismatched + 1;
                        $display("FAIL event: got duty=%0d busy=%0b at_target=%0b, required duty=%0d busy=%0b at_target=%0b",
                                 cur.duty, cur.busy, cur.at, exp.duty, exp.busy, exp.at);
                    end
                end
                if (cur.duty !== prev.duty) begin
                    if (!reset && step_flag) begin
                        compared = compared + 1;
                        if (cycle - last_step != FRAME) begin
                            mismatched = mismatched + 1;
                            $display("FAIL frame_spacing: got %0d cycles between steps, required %0d",
                                     cycle - last_step, FRAME);
                        end
                    end
                    last_step = cycle;
                    step_flag = cur.busy && !reset;
                end else if (!cur.busy) begin
                    step_flag = 1'b0;
                end
                prev = cur;
            end
        end
    end

    // Stimulus: directed phases, each pushing its hand-derived output changes.
    initial begin
        int lat;
        reset  = 1'b1;
        sw_pos = 1'b1;

        // Reset with the switch high: outputs at reset values.
        repeat (3) begin
            @(negedge clk);
            check("reset_duty", int'(duty_cycle), 21);
            check("reset_busy", int'(busy), 0);
            check("reset_at", int'(at_target), 0);
        end
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("pre_debounce_busy", int'(busy), 0);
        end
        check("pre_debounce_duty", int'(duty_cycle), 21);
        sw_pos = 1'b0;
        repeat (20) @(negedge clk);

        // Glitch of 5 cycles is rejected.
        sw_pos = 1'b1;
        repeat (5) @(negedge clk);
        sw_pos = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch_duty", int'(duty_cycle), 21);
        check("glitch_busy", int'(busy), 0);

        // Full ramp up 21 -> 102.
        push(21, 1'b1, 1'b0);
        for (int v = 25; v <= 101; v += 4) push(v, 1'b1, 1'b0);
        push(102, 1'b0, 1'b1);
        push(102, 1'b0, 1'b0);
        sw_pos = 1'b1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("busy_latency", lat, 11);
        wait_empty("ramp_up", 600);
        check("ramp_up_final", int'(duty_cycle), 102);

        // Full ramp down 102 -> 21.
        push(102, 1'b1, 1'b0);
        for (int v = 98; v >= 22; v -= 4) push(v, 1'b1, 1'b0);
        push(21, 1'b0, 1'b1);
        push(21, 1'b0, 1'b0);
        sw_pos = 1'b0;
        wait_empty("ramp_down", 600);

        // Reversal at 41.
        push(21, 1'b1, 1'b0);
        for (int v = 25; v <= 41; v += 4) push(v, 1'b1, 1'b0);
        sw_pos = 1'b1;
        wait_empty("rev_up", 300);
        sw_pos = 1'b0;
        for (int v = 37; v >= 25; v -= 4) push(v, 1'b1, 1'b0);
        push(21, 1'b0, 1'b1);
        push(21, 1'b0, 1'b0);
        wait_empty("rev_down", 300);

        // Reset mid-ramp at 61, then the ramp restarts from 21.
        push(21, 1'b1, 1'b0);
        for (int v = 25; v <= 61; v += 4) push(v, 1'b1, 1'b0);
        sw_pos = 1'b1;
        wait_empty("pre_reset_ramp", 400);
        check("mid_ramp_busy", int'(busy), 1);
        push(21, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_duty", int'(duty_cycle), 21);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_at", int'(at_target), 0);
        repeat (2) @(negedge clk);
        push(21, 1'b1, 1'b0);
        for (int v = 25; v <= 101; v += 4) push(v, 1'b1, 1'b0);
        push(102, 1'b0, 1'b1);
        push(102, 1'b0, 1'b0);
        reset = 1'b0;
        wait_empty("restart_ramp", 600);

        // Equal endpoints: the second instance saw every switch toggle above.
        check("eq_busy_cycles", eq_busy_seen, 0);
        check("eq_at_cycles", eq_at_seen, 0);
        check("eq_duty_off_cycles", eq_duty_bad, 0);
        check("eq_duty_final", int'(eq_duty), 50);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/servo_duty_ramp.md
# servo_duty_ramp

Upstream command stage for the servo PWM path. Turns a raw position switch into a 10-bit `duty_cycle` word for the PWM serializer. It synchronises and debounces the switch, then selects one of two duty endpoints. It slews the output toward that endpoint by a fixed step once per 20 ms servo frame, so the servo never gets a full-range jump in one period.

## Interface
Parameters:
- `FRAME_CYCLES`, 500_000: clock cycles per servo frame (20 ms at 25 MHz).
- `DEBOUNCE_CYCLES`, 250_000: consecutive cycles a new switch level must persist (10 ms).
- `DUTY_LO`, 21: duty word when the switch is 0; also the reset value.
- `DUTY_HI`, 102: duty word when the switch is 1.
- `STEP`, 4: maximum duty change per frame.
- Legal values: `0 <= DUTY_LO <= DUTY_HI <= 1023`, `STEP >= 1`, `FRAME_CYCLES >= 2`, `DEBOUNCE_CYCLES >= 1`.

Ports:
- `CLK25MHZ`  in  1  system clock, 25 MHz. This is the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sw_pos`  in  1  raw, asynchronous position switch.
- `duty_cycle`  out  10  registered duty word to the PWM serializer.
- `busy`  out  1  high while ramping.
- `at_target`  out  1  one-cycle pulse when a ramp lands on its target.

## Operation
- Synchroniser: two flops on `sw_pos`, both reset to 0. The second flop's output is `sw_sync`.
- Debouncer: holds a stable level `sw_stable` (reset 0) and a counter.
  - If `sw_sync == sw_stable`, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1` with `sw_sync` still differing, `sw_stable` takes `sw_sync` and the counter clears.
  - Pulses shorter than `DEBOUNCE_CYCLES` cycles are ignored.
- Target: `target = sw_stable ? DUTY_HI : DUTY_LO`. It is combinational from the registered `sw_stable`.
- Frame timer: free-running counter from 0 to `FRAME_CYCLES-1`, wrapping to 0.
  - `frame_tick` is high for the single cycle where the count equals `FRAME_CYCLES-1`.
  - The counter runs from reset and is never restarted by switch activity.
- FSM, two states (reset state HOLD):
  - HOLD: if `target != duty_cycle`, go to RAMP on the next edge. No duty change happens on that edge, even if `frame_tick` is high.
  - RAMP, on a `frame_tick` cycle:
    - `diff = |target - duty_cycle|`, computed in 11-bit unsigned so it cannot wrap.
    - If `diff <= STEP`: `duty_cycle <= target`, `at_target <= 1`, go to HOLD.
    - Else: `duty_cycle <= duty_cycle ± STEP`, toward `target`.
  - RAMP, without `frame_tick`: hold all state.
  - If `target` changes during RAMP, the next tick steps toward the new target. Reversal is allowed and there is no return to HOLD first.
  - If `target` becomes equal to `duty_cycle` during RAMP, the next tick gives `diff = 0`: `duty_cycle` is unchanged, `at_target` pulses, and the FSM goes to HOLD.
- `busy` is registered and equals (state == RAMP).
- `duty_cycle` never leaves `[DUTY_LO, DUTY_HI]` and never overshoots `target`.

## Timing
- Reset values: `duty_cycle = DUTY_LO`, `busy = 0`, `at_target = 0`, state HOLD, all counters 0, synchroniser and `sw_stable` 0.
- Reset mid-ramp: outputs return to their reset values immediately (asynchronously) and any ramp is abandoned.
- Switch-to-`sw_stable` latency: 2 synchroniser cycles plus `DEBOUNCE_CYCLES` cycles.
- `sw_stable` to `busy`: 1 cycle.
- First step: at the first `frame_tick` edge after `busy` rises.
- `duty_cycle`, `busy` and `at_target` all update on the same edge, directly from flops.
  - `at_target` is high for exactly one cycle.
  - `busy` falls on the same edge that `at_target` rises.
- Full-range ramp at defaults: 21 to 102 takes 21 frames. The values are 25, 29, …, 101 (20 steps), then 102.
- `duty_cycle` changes at most once per frame.

## Test plan
The bench overrides `FRAME_CYCLES = 16` and `DEBOUNCE_CYCLES = 8`, keeping the default duty values and `STEP`.
- Reset: assert `reset` for 3 cycles with `sw_pos = 1` -> `duty_cycle = 21`, `busy = 0`, `at_target = 0` during reset and until the debounce completes.
- Glitch rejection: drive `sw_pos` high for 5 cycles, then low -> `sw_stable` stays 0, `busy` never rises, `duty_cycle` stays 21.
- Full ramp up: hold `sw_pos = 1` -> `busy` rises 11 cycles after the edge. `duty_cycle` steps 25, 29, …, 101, 102 on 21 consecutive ticks, spaced 16 cycles apart. `at_target` pulses once with the final step to 102 and `busy` falls.
- Reversal: in the up-ramp, at `duty_cycle = 41`, drive `sw_pos = 0` and keep it low for the debounce -> the next tick after `sw_stable` falls gives 37, then 33, …, down to 21. Exactly one `at_target` pulse occurs, at the snap to 21.
- Reset mid-ramp: assert `reset` with `duty_cycle = 61` and `busy = 1` -> `duty_cycle = 21` and `busy = 0` with no clock edge needed. After release with `sw_pos = 1`, the ramp restarts from 21.
- Equal target: change switch parameters so that `DUTY_HI = DUTY_LO = 50` and toggle `sw_pos` -> `busy` never rises, `at_target` never pulses, `duty_cycle` stays 50.
